// File: rtl/tx_bitstream_gen.sv
// Serial bit source for the tag tx modulator: pilot zeros, preamble, payload, CRC-16, dummy '1'.
// One bit per rising edge of bitinclk; the CRC stage exists only when TX_CRC16_EN is defined.
module tx_bitstream_gen #(
  parameter logic [15:0] CRC_PRESET  = 16'hFFFF,
  parameter int          FM0_TREXT_Z = 12,
  parameter int          MIL_PILOT_Z = 4,
  parameter int          MIL_TREXT_Z = 16
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        bitinclk,
  input  logic [1:0]  m,
  input  logic        trext,
  input  logic [15:0] data_in,
  input  logic [4:0]  data_nbits,
  input  logic        data_last,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        bitin,
  output logic        violationin,
  output logic        txstopin,
  output logic        underrun
);

`ifdef TX_CRC16_EN
  typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, CRC, DUMMY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, DUMMY, STOP} state_t;
`endif

  // Preamble bit i lives at index i (first transmitted bit is bit 0).
  localparam logic [7:0] FM0_PRE = 8'b0010_0101;
  localparam logic [7:0] MIL_PRE = 8'b0011_1010;

  state_t      state, state_nxt;
  logic        bitinclk_q, adv;
  logic [4:0]  cnt, cnt_nxt;
  logic [14:0] shreg, shreg_nxt;
  logic        last_q, last_nxt;
  logic        bit_nxt, viol_nxt, stop_nxt, underrun_nxt;
  logic        need_word, to_tail, data_bit;
  logic [4:0]  pilot_len;
`ifdef TX_CRC16_EN
  logic [15:0] crc, crc_nxt;
  logic        fb;
`endif

  assign adv = bitinclk & ~bitinclk_q;

  always_comb begin
    if (m == 2'd0) pilot_len = trext ? 5'(FM0_TREXT_Z) : 5'd0;
    else           pilot_len = trext ? 5'(MIL_TREXT_Z) : 5'(MIL_PILOT_Z);
  end

  // cnt is the position inside PILOT/PREAMBLE/CRC, and the bits still to send in DATA.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    last_nxt     = last_q;
    bit_nxt      = bitin;
    viol_nxt     = violationin;
    stop_nxt     = txstopin;
    underrun_nxt = underrun;
    need_word    = 1'b0;
    to_tail      = 1'b0;
    data_bit     = 1'b0;
    data_ready   = 1'b0;
`ifdef TX_CRC16_EN
    crc_nxt      = crc;
    fb           = 1'b0;
`endif
    if (adv) begin
      case (state)
        IDLE: begin
          state_nxt = (pilot_len != 5'd0) ? PILOT : PREAMBLE;
          cnt_nxt   = 5'd0;
        end
        PILOT: begin
          if (cnt == pilot_len - 5'd1) begin
            state_nxt = PREAMBLE;
            cnt_nxt   = 5'd0;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
        PREAMBLE: begin
          if (cnt == 5'd5) need_word = 1'b1;
          else             cnt_nxt   = cnt + 5'd1;
        end
        DATA: begin
          if (cnt != 5'd0) begin
            data_bit  = shreg[14];
            shreg_nxt = {shreg[13:0], 1'b0};
            cnt_nxt   = cnt - 5'd1;
          end else if (last_q) begin
            to_tail = 1'b1;
          end else begin
            need_word = 1'b1;
          end
        end
`ifdef TX_CRC16_EN
        CRC: begin
          if (cnt == 5'd15) state_nxt = DUMMY;
          else              cnt_nxt   = cnt + 5'd1;
        end
`endif
        DUMMY:   state_nxt = STOP;
        default: state_nxt = state;
      endcase

      // A missing word never stalls the stream: flag it and close the frame.
      if (need_word) begin
        if (data_valid) begin
          data_ready = 1'b1;
          state_nxt  = DATA;
          data_bit   = data_in[15];
          shreg_nxt  = data_in[14:0];
          cnt_nxt    = (data_nbits == 5'd0) ? 5'd15 : data_nbits - 5'd1;
          last_nxt   = data_last;
        end else begin
          underrun_nxt = 1'b1;
          to_tail      = 1'b1;
        end
      end

      if (to_tail) begin
`ifdef TX_CRC16_EN
        state_nxt = CRC;
        cnt_nxt   = 5'd0;
`else
        state_nxt = DUMMY;
`endif
      end

      bit_nxt  = 1'b0;
      viol_nxt = 1'b0;
      stop_nxt = 1'b0;
      case (state_nxt)
        PREAMBLE: begin
          bit_nxt  = (m == 2'd0) ? FM0_PRE[cnt_nxt[2:0]] : MIL_PRE[cnt_nxt[2:0]];
          viol_nxt = (m == 2'd0) && (cnt_nxt == 5'd4);
        end
        DATA: begin
          bit_nxt = data_bit;
`ifdef TX_CRC16_EN
          fb      = crc[15] ^ data_bit;
          crc_nxt = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
`endif
        end
`ifdef TX_CRC16_EN
        CRC:     bit_nxt = ~crc[~cnt_nxt[3:0]];
`endif
        DUMMY, STOP: begin
          bit_nxt  = 1'b1;
          stop_nxt = 1'b1;
        end
        default: bit_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      bitinclk_q  <= 1'b0;
      state       <= IDLE;
      cnt         <= 5'd0;
      shreg       <= 15'd0;
      last_q      <= 1'b0;
      bitin       <= 1'b0;
      violationin <= 1'b0;
      txstopin    <= 1'b0;
      underrun    <= 1'b0;
`ifdef TX_CRC16_EN
      crc         <= CRC_PRESET;
`endif
    end else begin
      bitinclk_q  <= bitinclk;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      last_q      <= last_nxt;
      bitin       <= bit_nxt;
      violationin <= viol_nxt;
      txstopin    <= stop_nxt;
      underrun    <= underrun_nxt;
`ifdef TX_CRC16_EN
      crc         <= crc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tx_bitstream_gen.sv
// Randomized scoreboard bench for tx_bitstream_gen: expected bit stream built from the frame rules,
// compared bit by bit by a monitor on every advance.
`timescale 1ns/1ps
module tb_tx_bitstream_gen;
  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        bitinclk = 1'b0;
  logic [1:0]  m = 2'd0;
  logic        trext = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [4:0]  data_nbits = 5'd0;
  logic        data_last = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready, bitin, violationin, txstopin, underrun;

  int checks = 0;
  int failures = 0;

  // Expected entries: {bit, violation, txstop, data_ready-on-this-advance}
  logic [3:0]  exp_q[$];
  int          exp_idx;
  logic [15:0] src_dat[$];
  logic [4:0]  src_nb[$];
  logic        src_last[$];
  logic        monitor_en = 1'b0;
  logic        xfer = 1'b0;
  logic        bik_prev = 1'b0;
  logic        pend_adv = 1'b0;
  logic        pend_rdy = 1'b0;

  always #5 clkin = ~clkin;

  tx_bitstream_gen dut (
    .clkin(clkin), .reset(reset), .bitinclk(bitinclk), .m(m), .trext(trext),
    .data_in(data_in), .data_nbits(data_nbits), .data_last(data_last), .data_valid(data_valid),
    .data_ready(data_ready), .bitin(bitin), .violationin(violationin), .txstopin(txstopin),
    .underrun(underrun)
  );

  // Monitor: inputs settle 2ns after each rising edge, so the falling edge sees what the next
  // rising edge will act on, and the outputs produced by the previous one.
  always @(negedge clkin) begin
    if (reset || !monitor_en) begin
      pend_adv = 1'b0;
      pend_rdy = 1'b0;
      bik_prev = 1'b0;
    end else begin
      if (pend_adv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_advance bit=%b viol=%b stop=%b, required no further advance",
                   bitin, violationin, txstopin);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if ({bitin, violationin, txstopin, pend_rdy} !== e) begin
            failures++;
            $display("FAIL stream_bit[%0d] got bit/viol/stop/ready=%b required=%b",
                     exp_idx, {bitin, violationin, txstopin, pend_rdy}, e);
          end
          exp_idx++;
        end
      end
      pend_adv = bitinclk & ~bik_prev;
      pend_rdy = data_ready;
      bik_prev = bitinclk;
      if (pend_rdy && !pend_adv) begin
        checks++;
        failures++;
        $display("FAIL ready_without_advance got data_ready=1 required 0");
      end
      if (pend_rdy) xfer = 1'b1;
    end
  end

  // Word source: offers the head of the queue, pops it after an accepted transfer.
  always @(posedge clkin) begin
    #2;
    if (xfer) begin
      xfer = 1'b0;
      if (src_dat.size() != 0) begin
        void'(src_dat.pop_front());
        void'(src_nb.pop_front());
        void'(src_last.pop_front());
      end
    end
    data_valid = (src_dat.size() != 0);
    data_in    = data_valid ? src_dat[0]  : 16'h0;
    data_nbits = data_valid ? src_nb[0]   : 5'd0;
    data_last  = data_valid ? src_last[0] : 1'b0;
  end

  task automatic tick;
    @(posedge clkin);
    #2;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bitin, violationin, txstopin, underrun, data_ready} !== 5'b0) begin
      failures++;
      $display("FAIL %s got bit/viol/stop/underrun/ready=%b required=00000", name,
               {bitin, violationin, txstopin, underrun, data_ready});
    end
  endtask

  task automatic begin_stream;
    monitor_en = 1'b0;
    reset      = 1'b1;
    bitinclk   = 1'b0;
    xfer       = 1'b0;
    src_dat.delete();
    src_nb.delete();
    src_last.delete();
    exp_q.delete();
    exp_idx = 0;
    tick;
    check_zero("reset_state");
  endtask

  task automatic add_word(input logic [15:0] d, input logic [4:0] nb, input logic last);
    src_dat.push_back(d);
    src_nb.push_back(nb);
    src_last.push_back(last);
  endtask

  // Reference frame: pilot, preamble, payload words, complement of the CRC-16 remainder
  // (polynomial long division with the preset folded into the augmented message), dummy '1'.
  task automatic build_model(input logic [1:0] mm, input logic tt, output logic ur);
    int          npil;
    logic        msg[$];
    logic        a[$];
    logic [5:0]  fm0_seq;
    logic [5:0]  mil_seq;
    logic [16:0] poly;
    logic [15:0] rem;
    int          n;
    fm0_seq = 6'b101001;
    mil_seq = 6'b010111;
    poly    = 17'h11021;
    npil = (mm == 2'd0) ? (tt ? 12 : 0) : (tt ? 16 : 4);
    for (int i = 0; i < npil; i++) exp_q.push_back(4'b0000);
    for (int i = 0; i < 6; i++) begin
      if (mm == 2'd0) exp_q.push_back({fm0_seq[5-i], (i == 4), 2'b00});
      else            exp_q.push_back({mil_seq[5-i], 3'b000});
    end
    ur = 1'b1;
    for (int w = 0; w < src_dat.size(); w++) begin
      n = (src_nb[w] == 5'd0) ? 16 : int'(src_nb[w]);
      for (int j = 0; j < n; j++) begin
        exp_q.push_back({src_dat[w][15-j], 2'b00, (j == 0)});
        msg.push_back(src_dat[w][15-j]);
      end
      if (src_last[w]) begin
        ur = 1'b0;
        break;
      end
    end
`ifdef TX_CRC16_EN
    a = msg;
    for (int i = 0; i < 16; i++) a.push_back(1'b0);
    for (int i = 0; i < 16; i++) a[i] = ~a[i];
    for (int i = 0; i < msg.size(); i++)
      if (a[i])
        for (int k = 0; k < 17; k++) a[i+k] = a[i+k] ^ poly[16-k];
    for (int k = 0; k < 16; k++) rem[15-k] = a[msg.size()+k];
    for (int k = 15; k >= 0; k--) exp_q.push_back({~rem[k], 3'b000});
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1010);
  endtask

  task automatic adv_once(input int hold);
    int h;
    int l;
    h = (hold != 0) ? hold : $urandom_range(1, 5);
    l = $urandom_range(1, 4);
    bitinclk = 1'b1;
    repeat (h) tick;
    bitinclk = 1'b0;
    repeat (l) tick;
  endtask

  task automatic run_stream(input logic [1:0] mm, input logic tt, input int hold, input int abort_after);
    logic ur;
    int   budget;
    int   n;
    m = mm;
    trext = tt;
    build_model(mm, tt, ur);
    budget = exp_q.size() + 2;
    tick;
    reset = 1'b0;
    monitor_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (abort_after != 0 && n == abort_after) break;
      adv_once(hold);
      n++;
    end
    if (abort_after != 0) begin
      bitinclk = 1'b1;
      tick;
      reset = 1'b1;
      #1;
      check_zero("abort_reset");
      monitor_en = 1'b0;
      exp_q.delete();
    end else begin
      repeat (2) tick;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain got %0d bits missing required 0 (budget %0d advances)", exp_q.size(), budget);
      end
      checks++;
      if (underrun !== ur) begin
        failures++;
        $display("FAIL underrun got %b required %b", underrun, ur);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // FM0 single word, every bit held 5 clkin cycles
    begin_stream;
    add_word(16'hA5F0, 5'd16, 1'b1);
    run_stream(2'd0, 1'b0, 5, 0);

    // Miller M4 with extended pilot
    begin_stream;
    add_word(16'(($urandom)), 5'd16, 1'b1);
    run_stream(2'd2, 1'b1, 0, 0);

    // Short word then full word
    begin_stream;
    add_word(16'h3000, 5'd4, 1'b0);
    add_word(16'hFFFF, 5'd16, 1'b1);
    run_stream(2'd0, 1'b0, 0, 0);

    // No word at DATA entry
    begin_stream;
    run_stream(2'd1, 1'b0, 0, 0);

    // Source runs dry after a non-final word; nbits=0 means 16
    begin_stream;
    add_word(16'h8001, 5'd0, 1'b0);
    run_stream(2'd3, 1'b0, 0, 0);

    // Abort in mid-payload, then a clean stream
    begin_stream;
    add_word(16'hA5F0, 5'd16, 1'b0);
    add_word(16'h1234, 5'd16, 1'b1);
    run_stream(2'd0, 1'b0, 0, 14);
    begin_stream;
    add_word(16'hA5F0, 5'd16, 1'b1);
    run_stream(2'd0, 1'b0, 0, 0);

    for (int s = 0; s < 12; s++) begin
      int nw;
      begin_stream;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        add_word(16'($urandom), 5'($urandom_range(0, 16)),
                 (w == nw - 1) && ($urandom_range(0, 3) != 0));
      run_stream(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0);
    end

    begin_stream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
